// File: rtl/iomem_timer_pkg.sv
// Shared definitions for the iomem timer: register offsets, CTRL bit layout
// and the byte-strobe merge used by every read/write register.
package iomem_timer_pkg;

    // Register select values on iomem_addr[4:2]
    localparam logic [2:0] TMR_CTRL   = 3'd0;
    localparam logic [2:0] TMR_LOAD   = 3'd1;
    localparam logic [2:0] TMR_COUNT  = 3'd2;
    localparam logic [2:0] TMR_STATUS = 3'd3;
    localparam logic [2:0] TMR_PRESC  = 3'd4;

    // CTRL bit indices
    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IRQ_EN = 2;

    typedef struct packed {
        logic irq_en;   // bit 2
        logic auto_rl;  // bit 1
        logic en;       // bit 0
    } ctrl_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/iomem_timer_if.sv
// picosoc iomem request/acknowledge bundle as seen by one peripheral slot.
interface iomem_timer_if;
    // valid/ready: a request is accepted on the edge where valid=1 and
    // ready=0; ready is high for exactly that one following cycle, and rdata
    // is meaningful while ready=1.
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        iomem_ready;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_rdata, iomem_ready
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_rdata, iomem_ready
    );
endinterface

// File: rtl/iomem_timer_prescaler.sv
// Prescaler for the iomem timer: one tick every PRESC+1 cycles while enabled.
module iomem_timer_prescaler #(
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en_i,
    input  logic [PRE_W-1:0] presc_i,
    output logic             tick_o
);

    logic [PRE_W-1:0] pcnt_q;
    logic [PRE_W-1:0] pcnt_d;

    assign tick_o = en_i && (pcnt_q == presc_i);

    // >= rather than == so a PRESC lowered below the running count still wraps
    always_comb begin
        pcnt_d = pcnt_q + 1'b1;
        if (!en_i || (pcnt_q >= presc_i)) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/iomem_timer.sv
// Down-counting timer on the picosoc iomem bus with prescaler, auto-reload
// or one-shot mode and a level interrupt (EXP & IRQ_EN).
module iomem_timer
    import iomem_timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PRE_W = 16
) (
    input  logic          clk,
    input  logic          resetn,
    iomem_timer_if.slave  bus,
    output logic          irq
);

    ctrl_t            ctrl_q,  ctrl_d;
    logic [CNT_W-1:0] load_q,  load_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             exp_q,   exp_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             ready_q;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_sel;
    logic             tick;

    logic [2:0] sel;
    logic       access;
    logic       wr;
    logic       wr_ctrl, wr_load, wr_count, wr_presc, w1c_status;
    logic       unused_addr;

    assign sel         = bus.iomem_addr[4:2];
    assign unused_addr = ^{bus.iomem_addr[31:5], bus.iomem_addr[1:0]};

    // ready toggles with valid held, so each access is seen exactly once
    assign access = bus.iomem_valid && !ready_q;
    assign wr     = access && (bus.iomem_wstrb != 4'b0000);

    assign wr_ctrl    = wr && (sel == TMR_CTRL);
    assign wr_load    = wr && (sel == TMR_LOAD);
    assign wr_count   = wr && (sel == TMR_COUNT);
    assign wr_presc   = wr && (sel == TMR_PRESC);
    assign w1c_status = wr && (sel == TMR_STATUS) &&
                        bus.iomem_wstrb[0] && bus.iomem_wdata[0];

    iomem_timer_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk     (clk),
        .resetn  (resetn),
        .en_i    (ctrl_q.en),
        .presc_i (presc_q),
        .tick_o  (tick)
    );

    always_comb begin
        rdata_sel = 32'h0;
        case (sel)
            TMR_CTRL:   rdata_sel = 32'(ctrl_q);
            TMR_LOAD:   rdata_sel = 32'(load_q);
            TMR_COUNT:  rdata_sel = 32'(count_q);
            TMR_STATUS: rdata_sel = {31'h0, exp_q};
            TMR_PRESC:  rdata_sel = 32'(presc_q);
            default:    rdata_sel = 32'h0;
        endcase
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        exp_d   = exp_q;
        presc_d = presc_q;

        if (w1c_status) begin
            exp_d = 1'b0;
        end

        // A CPU write to CTRL or COUNT on a tick edge suppresses the tick;
        // an expiry on the same edge as a W1C overrides the clear above.
        if (tick && !(wr_ctrl || wr_count)) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else begin
                exp_d = 1'b1;
                if (ctrl_q.auto_rl) begin
                    count_d = load_q;
                end else begin
                    ctrl_d.en = 1'b0;
                end
            end
        end

        if (wr_ctrl) begin
            ctrl_d = ctrl_t'(3'(merge_bytes(32'(ctrl_q), bus.iomem_wdata, bus.iomem_wstrb)));
        end
        if (wr_load) begin
            load_d = CNT_W'(merge_bytes(32'(load_q), bus.iomem_wdata, bus.iomem_wstrb));
        end
        if (wr_count) begin
            count_d = CNT_W'(merge_bytes(32'(count_q), bus.iomem_wdata, bus.iomem_wstrb));
        end
        if (wr_presc) begin
            presc_d = PRE_W'(merge_bytes(32'(presc_q), bus.iomem_wdata, bus.iomem_wstrb));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            exp_q   <= 1'b0;
            presc_q <= '0;
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            exp_q   <= exp_d;
            presc_q <= presc_d;
            ready_q <= access;
            if (access) begin
                rdata_q <= rdata_sel;
            end
        end
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign irq             = exp_q && ctrl_q.irq_en;

endmodule

// File: tb/tb_iomem_timer.sv
// Directed bench for iomem_timer: read expectations go into a queue and a
// monitor checks them whenever the DUT raises ready.
module tb_iomem_timer;
    import iomem_timer_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    logic irq;

    iomem_timer_if bus ();

    iomem_timer #(
        .CNT_W (32),
        .PRE_W (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic        hold_mode = 1'b0;
    logic [31:0] hold_exp  = 32'h0;
    logic        prev_rdy  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
        end
    endtask

    task automatic bus_access(input logic [2:0] reg_i, input logic [3:0] strb,
                              input logic [31:0] data);
        @(negedge clk);
        bus.iomem_valid = 1'b1;
        bus.iomem_wstrb = strb;
        bus.iomem_addr  = {8'h08, 19'h0, reg_i, 2'b00};
        bus.iomem_wdata = data;
        @(posedge clk);
        #1 check("ready_rise", {31'h0, bus.iomem_ready}, 32'h1);
        @(negedge clk);
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [2:0] reg_i, input logic [31:0] data);
        bus_access(reg_i, 4'hf, data);
    endtask

    task automatic rd(input logic [2:0] reg_i, input logic [31:0] expv);
        exp_q.push_back(expv);
        bus_access(reg_i, 4'h0, 32'h0);
    endtask

    // Cycles from now until irq is seen high, capped at 200
    task automatic wait_irq(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!irq && n < 200);
    endtask

    // Monitor: every ready pulse must be single-cycle; reads pop the scoreboard
    always @(posedge clk) begin
        #2;
        if (bus.iomem_ready) begin
            check("ready_pulse", {31'h0, prev_rdy}, 32'h0);
            if (bus.iomem_wstrb == 4'h0) begin
                if (hold_mode) begin
                    check("hold_rdata", bus.iomem_rdata, hold_exp);
                end else if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_read: got 0x%08h, want no response", bus.iomem_rdata);
                end else begin
                    check("rdata", bus.iomem_rdata, exp_q.pop_front());
                end
            end
        end
        prev_rdy = bus.iomem_ready;
    end

    int n;

    initial begin
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_addr  = 32'h0;
        bus.iomem_wdata = 32'h0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        check("reset_ready", {31'h0, bus.iomem_ready}, 32'h0);
        check("reset_rdata", bus.iomem_rdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Reset values of every register, plus an unmapped slot
        rd(TMR_CTRL, 32'h0);
        rd(TMR_LOAD, 32'h0);
        rd(TMR_COUNT, 32'h0);
        rd(TMR_STATUS, 32'h0);
        rd(TMR_PRESC, 32'h0);
        rd(3'd5, 32'h0);
        @(posedge clk);
        #1 check("ready_one_cycle", {31'h0, bus.iomem_ready}, 32'h0);
        check("irq_after_reset", {31'h0, irq}, 32'h0);

        // Periodic, tick every cycle: expiry 4 cycles after enable
        wr(TMR_PRESC, 32'd0);
        wr(TMR_LOAD, 32'd3);
        wr(TMR_COUNT, 32'd3);
        wr(TMR_CTRL, 32'h7);
        wait_irq(n);
        check("period_first", n, 32'd4);
        wr(TMR_STATUS, 32'h1);
        check("w1c_drops_irq", {31'h0, irq}, 32'h0);
        // W1C landed one cycle after expiry, so the next one is 3 cycles on
        wait_irq(n);
        check("period_second", n, 32'd3);

        // W1C on the exact expiry edge: set wins
        wr(TMR_STATUS, 32'h1);
        check("w1c_drops_irq2", {31'h0, irq}, 32'h0);
        repeat (2) @(posedge clk);
        wr(TMR_STATUS, 32'h1);
        check("w1c_vs_expiry", {31'h0, irq}, 32'h1);
        rd(TMR_STATUS, 32'h1);

        // COUNT write on a tick edge wins over the decrement
        wr(TMR_CTRL, 32'h0);
        wr(TMR_PRESC, 32'd3);
        wr(TMR_COUNT, 32'd20);
        wr(TMR_CTRL, 32'h3);
        repeat (3) @(posedge clk);
        wr(TMR_COUNT, 32'd7);
        rd(TMR_COUNT, 32'd7);

        // One-shot: 3 ticks of 10 cycles, then EN self-clears
        wr(TMR_CTRL, 32'h0);
        wr(TMR_STATUS, 32'h1);
        wr(TMR_PRESC, 32'd9);
        wr(TMR_COUNT, 32'd2);
        wr(TMR_CTRL, 32'h5);
        wait_irq(n);
        check("oneshot_delay", n, 32'd30);
        rd(TMR_CTRL, 32'h4);
        rd(TMR_COUNT, 32'h0);
        rd(TMR_STATUS, 32'h1);

        // Byte strobes and ignored writes
        wr(TMR_LOAD, 32'h0);
        bus_access(TMR_LOAD, 4'b0010, 32'hAABBCCDD);
        rd(TMR_LOAD, 32'h0000CC00);
        wr(TMR_PRESC, 32'h0);
        bus_access(TMR_PRESC, 4'b0001, 32'h00001234);
        rd(TMR_PRESC, 32'h00000034);
        bus_access(TMR_STATUS, 4'b0010, 32'h00000001);
        rd(TMR_STATUS, 32'h1);
        wr(TMR_STATUS, 32'h1);
        rd(TMR_STATUS, 32'h0);
        wr(3'd6, 32'hFFFFFFFF);
        rd(3'd6, 32'h0);

        // Async reset mid-count with valid held
        wr(TMR_PRESC, 32'd0);
        wr(TMR_LOAD, 32'd5);
        wr(TMR_COUNT, 32'd5);
        wr(TMR_CTRL, 32'h7);
        wait_irq(n);
        check("period_load5", n, 32'd6);
        @(negedge clk);
        hold_exp        = 32'h7;
        hold_mode       = 1'b1;
        bus.iomem_valid = 1'b1;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_addr  = {8'h08, 19'h0, TMR_CTRL, 2'b00};
        repeat (5) @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!bus.iomem_ready && n < 10);
        check("hold_ready_seen", {31'h0, bus.iomem_ready}, 32'h1);
        #2 resetn = 1'b0;
        #1;
        check("async_ready", {31'h0, bus.iomem_ready}, 32'h0);
        check("async_rdata", bus.iomem_rdata, 32'h0);
        check("async_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        hold_mode       = 1'b0;
        bus.iomem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(posedge clk);
        #1 check("idle_after_reset", {31'h0, irq}, 32'h0);
        rd(TMR_COUNT, 32'h0);
        rd(TMR_CTRL, 32'h0);
        rd(TMR_LOAD, 32'h0);
        wr(TMR_COUNT, 32'd2);
        wr(TMR_CTRL, 32'h7);
        wait_irq(n);
        check("fresh_config", n, 32'd3);

        repeat (3) @(posedge clk);
        check("queue_drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
